// File: rtl/vram_bus_arbiter.sv
// Memory bus arbiter: the CPU owns the bus by default and is halted to hand it to one of two DMA masters.
// Round-robin between the DMA ports; a burst cap plus a CPU cool-down keeps the CPU making progress.
//
//   state     | meaning
//   IDLE      | CPU owns the bus; counting down cool-down or looking for a request
//   HALT_WAIT | halt raised, waiting for the CPU to report the bus available
//   GRANT     | winner owns the bus; burst cycles counted
//   DEAD      | one masked cycle while ownership passes directly to the other DMA port
//   RELEASE   | one masked cycle while the bus returns to the CPU
module vram_bus_arbiter #(
    parameter int BURST_MAX = 64,
    parameter int CPU_MIN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_cs,
    input  logic        cpu_rw,
    output logic        cpu_halt,
    input  logic        cpu_ba,
    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        cs0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [15:0] addr1,
    input  logic        cs1,
    output logic        gnt1,
    output logic [15:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_rw,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        GRANT     = 3'd2,
        DEAD      = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
    localparam logic [7:0] COOL_LOAD  = 8'(CPU_MIN);

    state_t     state_q, state_d;
    logic       cpu_halt_q, cpu_halt_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       winner_q, winner_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] cool_cnt_q, cool_cnt_d;
    logic [1:0] req;

    assign req = {req1, req0};

    always_comb begin
        state_d     = state_q;
        cpu_halt_d  = cpu_halt_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        winner_d    = winner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        cool_cnt_d  = cool_cnt_q;

        case (state_q)
            IDLE: begin
                if (cool_cnt_q != 8'd0) begin
                    cool_cnt_d = cool_cnt_q - 8'd1;
                end else if (|req) begin
                    // On a tie the port that was not granted last wins.
                    winner_d   = (&req) ? ~rr_ptr_q : req[1];
                    cpu_halt_d = 1'b1;
                    state_d    = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (!req[winner_q]) begin
                    cpu_halt_d = 1'b0;
                    state_d    = IDLE;
                end else if (cpu_ba) begin
                    gnt0_d      = ~winner_q;
                    gnt1_d      = winner_q;
                    rr_ptr_d    = winner_q;
                    burst_cnt_d = 8'd0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                burst_cnt_d = burst_cnt_q + 8'd1;
                if (!req[winner_q]) begin
                    gnt0_d = 1'b0;
                    gnt1_d = 1'b0;
                    if (req[~winner_q]) begin
                        winner_d = ~winner_q;
                        state_d  = DEAD;
                    end else begin
                        cpu_halt_d = 1'b0;
                        state_d    = RELEASE;
                    end
                end else if (burst_cnt_q == BURST_LAST) begin
                    gnt0_d     = 1'b0;
                    gnt1_d     = 1'b0;
                    cpu_halt_d = 1'b0;
                    state_d    = RELEASE;
                end
            end
            DEAD: begin
                if (req[winner_q]) begin
                    gnt0_d      = ~winner_q;
                    gnt1_d      = winner_q;
                    rr_ptr_d    = winner_q;
                    burst_cnt_d = 8'd0;
                    state_d     = GRANT;
                end else begin
                    cpu_halt_d = 1'b0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                cool_cnt_d = COOL_LOAD;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cpu_halt_q  <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            winner_q    <= 1'b0;
            rr_ptr_q    <= 1'b1;
            burst_cnt_q <= 8'd0;
            cool_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cpu_halt_q  <= cpu_halt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
        end
    end

    // DMA masters only read; hand-over cycles keep the bus deselected.
    always_comb begin
        mem_addr = cpu_addr;
        mem_cs   = cpu_cs;
        mem_rw   = cpu_rw;
        if (gnt0_q) begin
            mem_addr = addr0;
            mem_cs   = cs0 & gnt0_q;
            mem_rw   = 1'b1;
        end else if (gnt1_q) begin
            mem_addr = addr1;
            mem_cs   = cs1 & gnt1_q;
            mem_rw   = 1'b1;
        end else if (state_q == DEAD || state_q == RELEASE) begin
            mem_cs = 1'b0;
            mem_rw = 1'b1;
        end
    end

    assign cpu_halt = cpu_halt_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign busy     = (state_q != IDLE);

endmodule
